// File: rtl/wb_keypad_pkg.sv
// wb_keypad_pkg: register offsets, KEYDATA/STATUS bit positions and debouncer states
package wb_keypad_pkg;
    localparam logic [7:0] ADR_CTRL    = 8'h00;
    localparam logic [7:0] ADR_STATUS  = 8'h04;
    localparam logic [7:0] ADR_KEYDATA = 8'h08;
    localparam logic [7:0] ADR_SCANDIV = 8'h0C;
    localparam int KD_VALID = 8;
    localparam int KD_REL   = 9;
    localparam int ST_OVF   = 1;
    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} deb_state_t;
endpackage

// File: rtl/keypad_event_fifo.sv
// keypad_event_fifo: synchronous event FIFO with count and sticky overflow flag
module keypad_event_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clr_ovf,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            wptr     <= wptr + AW'(do_push);
            rptr     <= rptr + AW'(do_pop);
            count    <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
            overflow <= (push && !do_push) ? 1'b1 : clr_ovf ? 1'b0 : overflow;
        end
    end
endmodule

// File: rtl/wb_keypad_scan.sv
// wb_keypad_scan: Wishbone matrix keypad scanner with debouncer and event FIFO.
// Define KEYPAD_RELEASE_EVT_EN to also queue key-release events.
module wb_keypad_scan import wb_keypad_pkg::*; #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SCAN_DIV_RST = 50000,
    parameter int DEBOUNCE     = 3,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_stb_i,
    input  logic             wb_cyc_i,
    output logic             wb_ack_o,
    input  logic             wb_we_i,
    input  logic [31:0]      wb_adr_i,
    input  logic [3:0]       wb_sel_i,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    output logic             intr,
    input  logic [ROWS-1:0]  row_in,
    output logic [COLS-1:0]  col_out
);
`ifdef KEYPAD_RELEASE_EVT_EN
    localparam logic REL_EN = 1'b1;
`else
    localparam logic REL_EN = 1'b0;
`endif
    localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
    localparam int FW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] DB = 4'(DEBOUNCE);
    logic ack, bus_req, wr, fifo_pop, fifo_push, empty, full, overflow, en, last, frame_done;
    logic have, f_have, c_hit, push, rel;
    logic [1:0] ctrl;
    logic [7:0] adr, best, f_best, c_code, cand, ncand;
    logic [19:0] scandiv, div_cnt;
    logic [CW-1:0] col;
    logic [ROWS-1:0] row_s1, row_s;
    logic [3:0] cnt, ncnt;
    logic [8:0] fifo_din, fifo_dout;
    logic [FW-1:0] count;
    logic [31:0] rd_data;
    deb_state_t state, nstate;
    logic unused;
    assign unused   = ^{wb_sel_i, wb_adr_i[31:8], wb_dat_i[31:20]};
    assign adr      = wb_adr_i[7:0];
    assign bus_req  = wb_stb_i && wb_cyc_i;
    assign wb_ack_o = bus_req && ack;
    assign wr       = wb_ack_o && wb_we_i;
    // pop only when the captured read data actually carried an entry
    assign fifo_pop = wb_ack_o && !wb_we_i && adr == ADR_KEYDATA && wb_dat_o[KD_VALID];
    assign rd_data  = adr == ADR_CTRL    ? {30'd0, ctrl} :
                      adr == ADR_STATUS  ? {16'd0, 8'(count), 6'd0, overflow, !empty} :
                      adr == ADR_KEYDATA ? (empty ? 32'd0 : {22'd0, fifo_dout[8], 1'b1, fifo_dout[7:0]}) :
                      adr == ADR_SCANDIV ? {12'd0, scandiv} : 32'd0;
    always_ff @(posedge clk) begin
        if (reset) begin
            ack      <= 1'b0;
            wb_dat_o <= '0;
            ctrl     <= '0;
            scandiv  <= 20'(SCAN_DIV_RST);
            intr     <= 1'b0;
        end else begin
            ack      <= bus_req && !ack;
            wb_dat_o <= (bus_req && !ack) ? rd_data : '0;
            if (wr && adr == ADR_CTRL) ctrl <= wb_dat_i[1:0];
            if (wr && adr == ADR_SCANDIV) scandiv <= wb_dat_i[19:0] == '0 ? 20'd1 : wb_dat_i[19:0];
            intr     <= ctrl[1] && !empty;
        end
    end
    assign en         = ctrl[0];
    assign col_out    = en ? ~(COLS'(1) << col) : '1;
    assign last       = div_cnt >= scandiv - 20'd1;
    assign frame_done = en && last && col == CW'(COLS - 1);
    always_ff @(posedge clk) begin
        row_s1 <= reset ? '1 : row_in;
        row_s  <= reset ? '1 : row_s1;
    end
    always_comb begin
        c_hit  = 1'b0;
        c_code = '0;
        for (int r = ROWS - 1; r >= 0; r--)
            if (!row_s[r]) begin
                c_hit  = 1'b1;
                c_code = 8'(r * COLS) + 8'(col);
            end
        f_have = have || c_hit;
        f_best = (c_hit && (!have || c_code < best)) ? c_code : best;
    end
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            div_cnt <= '0;
            col     <= '0;
            have    <= 1'b0;
            best    <= '0;
        end else if (last) begin
            div_cnt <= '0;
            col     <= col == CW'(COLS - 1) ? '0 : col + 1'b1;
            have    <= frame_done ? 1'b0 : f_have;
            best    <= frame_done ? '0 : f_best;
        end else begin
            div_cnt <= div_cnt + 20'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            state <= IDLE;
            cnt   <= '0;
            cand  <= '0;
        end else begin
            state <= nstate;
            cnt   <= ncnt;
            cand  <= ncand;
        end
    end
    always_comb begin
        nstate = state;
        ncnt   = cnt;
        ncand  = cand;
        push   = 1'b0;
        rel    = 1'b0;
        if (frame_done)
            case (state)
                IDLE: if (f_have) begin
                    ncand  = f_best;
                    ncnt   = 4'd1;
                    push   = DB == 4'd1;
                    nstate = DB == 4'd1 ? HELD : PRESS_CHK;
                end
                PRESS_CHK: if (f_have && f_best == cand) begin
                    ncnt   = cnt + 4'd1;
                    push   = ncnt == DB;
                    nstate = ncnt == DB ? HELD : PRESS_CHK;
                end else nstate = IDLE;
                HELD: if (!f_have) begin
                    ncnt   = 4'd1;
                    rel    = DB == 4'd1;
                    nstate = DB == 4'd1 ? IDLE : REL_CHK;
                end
                default: if (f_have && f_best == cand) nstate = HELD;
                else begin
                    ncnt   = cnt + 4'd1;
                    rel    = ncnt == DB;
                    nstate = ncnt == DB ? IDLE : REL_CHK;
                end
            endcase
    end
    assign fifo_push = push || (rel && REL_EN);
    assign fifo_din  = {rel && REL_EN, ncand};
    keypad_event_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .push(fifo_push), .pop(fifo_pop),
        .clr_ovf(wr && adr == ADR_STATUS && wb_dat_i[ST_OVF]), .din(fifo_din),
        .dout(fifo_dout), .full(full), .empty(empty), .overflow(overflow), .count(count)
    );
endmodule
